// File: rtl/shift_arbiter.sv
// shift_arbiter: arbitrates NUM_REQ valid/ready requesters onto one shared barrel shifter with a one-entry tagged result slot.
// Define SHIFT_ARB_FIXED_PRIO_EN for fixed lowest-index priority; round-robin otherwise.
module barrel_shifter #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         data_i,
    input  logic [$clog2(WIDTH)-1:0] shamt_i,
    input  logic                     dir_i,
    output logic [WIDTH-1:0]         result_o
);
    localparam int SW = $clog2(WIDTH);
    logic [WIDTH-1:0] stage [SW+1];
    assign stage[0] = data_i;
    for (genvar s = 0; s < SW; s++) begin : g_stage
        assign stage[s+1] = !shamt_i[s] ? stage[s] :
                            dir_i ? stage[s] >> (2**s) : stage[s] << (2**s);
    end
    assign result_o = stage[SW];
endmodule

module shift_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]           req_data,
    input  logic [NUM_REQ*$clog2(WIDTH)-1:0]   req_shamt,
    input  logic [NUM_REQ-1:0]                 req_dir,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [WIDTH-1:0]                   rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]         rsp_id
);
    localparam int SW = $clog2(WIDTH);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic {EMPTY, FULL} state_e;
    state_e            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [IW-1:0]     id_q, id_d;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_any, slot_free, grant;
    logic [WIDTH-1:0]  sel_data, shifted;
    logic [SW-1:0]     sel_shamt;
    logic              sel_dir;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
    logic [IW-1:0]     ptr_q, ptr_d;
`endif
    // Scan from the far end back toward the start so the candidate nearest the start wins.
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (int'(ptr_q) + k) % NUM_REQ;
`endif
            if (req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
    end
    assign slot_free = (state_q == EMPTY) || rsp_ready;
    assign grant     = slot_free && gnt_any;
    always_comb begin
        req_ready = '0;
        if (grant) req_ready[gnt_idx] = 1'b1;
    end
    assign sel_data  = req_data[gnt_idx*WIDTH +: WIDTH];
    assign sel_shamt = req_shamt[gnt_idx*SW +: SW];
    assign sel_dir   = req_dir[gnt_idx];
    barrel_shifter #(.WIDTH(WIDTH)) u_shifter (
        .data_i   (sel_data),
        .shamt_i  (sel_shamt),
        .dir_i    (sel_dir),
        .result_o (shifted)
    );
    always_comb begin
        state_d = grant ? FULL : (rsp_ready ? EMPTY : state_q);
        data_d  = grant ? shifted : data_q;
        id_d    = grant ? gnt_idx : id_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end
`ifndef SHIFT_ARB_FIXED_PRIO_EN
    assign ptr_d = grant ? IW'((int'(gnt_idx) + 1) % NUM_REQ) : ptr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`endif
    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
endmodule
